alu_cmp_stage: RTL

- Registered stage directly downstream of the 16-bit adder/subtractor.
- Consumes the adder's sum/difference, carry-out and z/v/n flags, and produces either the arithmetic result or a compare result (EQ/LT/LE, signed and unsigned), zero-extended to WIDTH.
- Holds a packed flag word and a saturating overflow-event counter.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the writeback side can stall without a combinational ready path.

---
 rtl/alu_cmp_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_cmp_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmp_stage
// Purpose  : Registered result/compare stage behind the adder/subtractor.
//            Selects the arithmetic result or a signed/unsigned compare bit,
//            captures {z,v,n,c}, counts overflow events (saturating) and
//            decouples upstream from downstream with a 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmp_stage #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_cout,
    input  logic             in_z,
    input  logic             in_v,
    input  logic             in_n,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_flags,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [2:0]       c_op_cmpeq  = 3'b001;
    localparam logic [2:0]       c_op_cmplt  = 3'b010;
    localparam logic [2:0]       c_op_cmple  = 3'b011;
    localparam logic [2:0]       c_op_cmpltu = 3'b100;
    localparam logic [2:0]       c_op_cmpleu = 3'b101;
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

    // Main (output) register
    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic [3:0]       r_main_flags;

    // Skid register, only occupied while main is full and stalled
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic [3:0]       r_skid_flags;

    logic [CNT_W-1:0] r_ovf_count;

    logic             w_in_fire;
    logic             w_main_free;
    logic             w_is_cmp;
    logic             w_cmp_bit;
    logic [WIDTH-1:0] w_sel_data;
    logic [3:0]       w_sel_flags;

    // Ready depends only on a register, so no combinational path from out_ready
    assign in_ready    = ~r_skid_valid;
    assign w_in_fire   = in_valid & ~r_skid_valid;
    // Main can take a new beat when empty or when its current beat leaves now
    assign w_main_free = ~r_main_valid | out_ready;
    assign w_sel_flags = {in_z, in_v, in_n, in_cout};

    // Decode the function select into either a pass-through or a compare bit;
    // compares interpret the flags of a subtraction a-b
    always_comb begin
        w_is_cmp  = 1'b0;
        w_cmp_bit = 1'b0;
        case (in_op)
            c_op_cmpeq: begin
                w_is_cmp  = 1'b1;
                w_cmp_bit = in_z;
            end
            c_op_cmplt: begin
                w_is_cmp  = 1'b1;
                w_cmp_bit = in_n ^ in_v;
            end
            c_op_cmple: begin
                w_is_cmp  = 1'b1;
                w_cmp_bit = in_z | (in_n ^ in_v);
            end
            c_op_cmpltu: begin
                w_is_cmp  = 1'b1;
                w_cmp_bit = ~in_cout;
            end
            c_op_cmpleu: begin
                w_is_cmp  = 1'b1;
                w_cmp_bit = ~in_cout | in_z;
            end
            default: begin
                w_is_cmp  = 1'b0;
                w_cmp_bit = 1'b0;
            end
        endcase
        w_sel_data = w_is_cmp ? {{(WIDTH-1){1'b0}}, w_cmp_bit} : in_result;
    end

    // Two-entry FIFO: skid drains into main first, otherwise a new beat loads
    // main if it is free or lands in skid when main is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_flags <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_flags <= '0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_data  <= r_skid_data;
                r_main_flags <= r_skid_flags;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_main_valid <= 1'b1;
                r_main_data  <= w_sel_data;
                r_main_flags <= w_sel_flags;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= w_sel_data;
            r_skid_flags <= w_sel_flags;
        end
    end

    // Overflow events are counted when the beat is accepted; sticks at max
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_count <= '0;
        end else if (w_in_fire && in_v && (r_ovf_count != c_cnt_max)) begin
            r_ovf_count <= r_ovf_count + 1'b1;
        end
    end

    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign out_flags = r_main_flags;
    assign ovf_count = r_ovf_count;

endmodule
`default_nettype wire
